// File: rtl/fft_demux4_complex.sv
// rtl/fft_demux4_complex.sv - serial-to-parallel 4-lane complex sample distributor
// Collects four complex samples into lanes A..D and presents them as one group.
module fft_demux4_complex #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_sof_i,
    input  logic [WORD_SIZE-1:0] in_re_i,
    input  logic [WORD_SIZE-1:0] in_im_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WORD_SIZE-1:0] out_a_re_o,
    output logic [WORD_SIZE-1:0] out_a_im_o,
    output logic [WORD_SIZE-1:0] out_b_re_o,
    output logic [WORD_SIZE-1:0] out_b_im_o,
    output logic [WORD_SIZE-1:0] out_c_re_o,
    output logic [WORD_SIZE-1:0] out_c_im_o,
    output logic [WORD_SIZE-1:0] out_d_re_o,
    output logic [WORD_SIZE-1:0] out_d_im_o,
    output logic [1:0]           lane_idx_o,
    output logic                 err_drop_o
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           lane_idx_q, lane_idx_d;
    logic                 err_drop_q, err_drop_d;
    logic [WORD_SIZE-1:0] lane_re_q [4];
    logic [WORD_SIZE-1:0] lane_im_q [4];
    logic [WORD_SIZE-1:0] lane_re_d [4];
    logic [WORD_SIZE-1:0] lane_im_d [4];

    logic       accept;
    logic [1:0] target;

    // In HOLD the input is only open while the group is being consumed this cycle.
    assign in_ready_o = (state_q == FILL) || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign target     = in_sof_i ? 2'd0 : lane_idx_q;

    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        err_drop_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane_re_d[i] = lane_re_q[i];
            lane_im_d[i] = lane_im_q[i];
        end

        if (accept) begin
            lane_re_d[target] = in_re_i;
            lane_im_d[target] = in_im_i;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    lane_idx_d = target + 2'd1;
                    err_drop_d = in_sof_i && (lane_idx_q != 2'd0);
                    if (target == 2'd3) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // lane_idx has already wrapped to 0, so an accept here always targets lane A.
                if (out_ready_i) begin
                    state_d    = FILL;
                    lane_idx_d = accept ? 2'd1 : 2'd0;
                end
            end
            default: begin
                state_d    = FILL;
                lane_idx_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FILL;
            lane_idx_q <= 2'd0;
            err_drop_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lane_re_q[i] <= '0;
                lane_im_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
            err_drop_q <= err_drop_d;
            for (int i = 0; i < 4; i++) begin
                lane_re_q[i] <= lane_re_d[i];
                lane_im_q[i] <= lane_im_d[i];
            end
        end
    end

    assign out_valid_o = (state_q == HOLD);
    assign lane_idx_o  = lane_idx_q;
    assign err_drop_o  = err_drop_q;
    assign out_a_re_o  = lane_re_q[0];
    assign out_a_im_o  = lane_im_q[0];
    assign out_b_re_o  = lane_re_q[1];
    assign out_b_im_o  = lane_im_q[1];
    assign out_c_re_o  = lane_re_q[2];
    assign out_c_im_o  = lane_im_q[2];
    assign out_d_re_o  = lane_re_q[3];
    assign out_d_im_o  = lane_im_q[3];

endmodule
